// File: rtl/xor_lfi_pkg.sv
// Shared definitions for the laser fault-injection XOR target and its monitor:
// FSM state encoding and the default sizing constants.
package xor_lfi_pkg;

    localparam int DEF_WIDTH         = 6;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_SAMPLE = 2'd3
    } mon_state_t;

endpackage

// File: rtl/xor_fault_monitor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the asynchronous input, then re-register to resolve metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/xor_fault_monitor.sv
// Steps a pattern into the XOR target, waits for it to settle, compares the
// synchronized q against the expected parity and reports mismatches to the host.
module xor_fault_monitor
    import xor_lfi_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [WIDTH-1:0] a_out,
    input  logic             q_in,
    output logic             busy,
    output logic             fault_valid,
    output logic [WIDTH-1:0] fault_pattern,
    output logic             fault_q,
    input  logic             fault_ack,
    output logic [CNT_W-1:0] fault_count,
    output logic             overflow
);

    // SETTLE lasts SETTLE_CYCLES-1 cycles: counter counts from SETTLE_CYCLES-2 down to 0.
    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 2);

    mon_state_t      state, state_nxt;
    logic [SC_W-1:0] settle_cnt;
    logic            first_drive;
    logic            q_sync;
    logic            fault;

    sync_2ff u_q_sync (
        .clk (clk),
        .rst (rst),
        .d   (q_in),
        .q   (q_sync)
    );

    assign busy  = (state != ST_IDLE);
    assign fault = (state == ST_SAMPLE) && (q_sync != ^a_out);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; stop overrides every transition.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_DRIVE;
            ST_DRIVE:  state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == '0) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = ST_DRIVE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (stop) state_nxt = ST_IDLE;
    end

    // Pattern stepping and settle timing; a fresh start always begins at pattern 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out       <= '0;
            settle_cnt  <= '0;
            first_drive <= 1'b0;
        end else begin
            if (state == ST_IDLE && start && !stop) first_drive <= 1'b1;
            if (state == ST_DRIVE) begin
                a_out       <= first_drive ? '0 : a_out + WIDTH'(1);
                settle_cnt  <= SETTLE_LOAD;
                first_drive <= 1'b0;
            end else if (state == ST_SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - SC_W'(1);
            end
        end
    end

    // Saturating fault counter; clear takes effect before a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_count <= '0;
        end else if (clear) begin
            fault_count <= fault ? CNT_W'(1) : '0;
        end else if (fault && fault_count != '1) begin
            fault_count <= fault_count + CNT_W'(1);
        end
    end

    // Sticky overflow: a new fault found an unacknowledged report still pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (fault && fault_valid && !fault_ack) begin
            overflow <= 1'b1;
        end else if (clear) begin
            overflow <= 1'b0;
        end
    end

    // Report handshake; a pending report is never overwritten unless acked the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_valid   <= 1'b0;
            fault_pattern <= '0;
            fault_q       <= 1'b0;
        end else if (fault && (!fault_valid || fault_ack)) begin
            fault_valid   <= 1'b1;
            fault_pattern <= a_out;
            fault_q       <= q_sync;
        end else if (fault_ack) begin
            fault_valid <= 1'b0;
        end
    end

endmodule
